// File: rtl/byte_stream_packer_pkg.sv
// Shared types and the lane-mapping helper for byte_stream_packer.
package byte_stream_packer_pkg;

  typedef enum logic {FILL, LAST} state_e;

  typedef logic [2:0] idx_t;

  localparam int NB_W = 4;

  // Big-endian mirrors the lane so the first byte lands in the top byte.
  function automatic idx_t lane_of(idx_t idx, bit big_endian, int nbytes);
    return big_endian ? idx_t'(nbytes - 1 - int'(idx)) : idx;
  endfunction

endpackage

// File: rtl/byte_stream_packer_oreg.sv
// One-entry output slot: load wins over drain; data held while valid & !ready.
// Optional BYTE_STREAM_PACKER_FLUSH_EN adds the byte-count side channel.
module byte_stream_packer_oreg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
  input  logic [3:0]   load_nbytes,
  output logic [3:0]   out_nbytes,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
      out_nbytes <= '0;
`endif
    end else if (load) begin
      out_valid  <= 1'b1;
      out_data   <= load_data;
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
      out_nbytes <= load_nbytes;
`endif
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/byte_stream_packer.sv
// Packs a valid/ready byte stream into NBYTES-wide words with elaboration-time byte order.
// Define BYTE_STREAM_PACKER_FLUSH_EN to add flush / out_nbytes (partial-word emit).
module byte_stream_packer
  import byte_stream_packer_pkg::*;
#(
  parameter int NBYTES     = 4,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
  input  logic                flush,
  output logic [NB_W-1:0]     out_nbytes,
`endif
  output logic [CNT_W-1:0]    word_cnt
);

  localparam int   W        = 8 * NBYTES;
  localparam idx_t LAST_IDX = idx_t'(NBYTES - 1);

  state_e          state_q, state_d;
  idx_t            idx_q, idx_d, lane;
  logic [W-1:0]    acc_q, acc_d, acc_wr;
  logic            slot_free, accept, load;
  logic [NB_W-1:0] load_nbytes;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    slot_free   = !out_valid || out_ready;
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
    // A pending flush needs the slot, so it stalls input until the slot frees.
    in_ready    = slot_free || (!flush && state_q == FILL);
`else
    in_ready    = slot_free || state_q == FILL;
`endif
    accept      = in_valid && in_ready;
    lane        = lane_of(idx_q, BIG_ENDIAN, NBYTES);
    acc_wr      = acc_q;
    for (int l = 0; l < NBYTES; l++)
      if (accept && lane == idx_t'(l)) acc_wr[8*l +: 8] = in_data;
    load        = accept && state_q == LAST;
    load_nbytes = NB_W'(NBYTES);
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
    if (flush && slot_free && (idx_q != '0 || accept)) begin
      load        = 1'b1;
      load_nbytes = NB_W'(idx_q) + NB_W'(accept);
    end
`endif
    idx_d = idx_q;
    acc_d = acc_wr;
    if (load) begin
      idx_d = '0;
      acc_d = '0;
    end else if (accept) begin
      idx_d = idx_q + idx_t'(1);
    end
    state_d = (idx_d == LAST_IDX) ? LAST : FILL;
  end

  byte_stream_packer_oreg #(.W(W)) u_oreg (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_data   (acc_wr),
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
    .load_nbytes (load_nbytes),
    .out_nbytes  (out_nbytes),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst)                         word_cnt <= '0;
    else if (out_valid && out_ready) word_cnt <= word_cnt + CNT_W'(1);
  end

`ifndef BYTE_STREAM_PACKER_FLUSH_EN
  logic unused_nb;
  assign unused_nb = ^load_nbytes;
`endif

endmodule

// File: tb/tb_byte_stream_packer.sv
// Bench for byte_stream_packer: big- and little-endian instances side by side, CNT_W=4.
module tb_byte_stream_packer;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        be_ir, le_ir, be_ov, le_ov;
  logic [31:0] be_od, le_od;
  logic [3:0]  be_cnt, le_cnt;
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
  logic        flush;
  logic [3:0]  be_nb, le_nb;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_stream_packer #(.NBYTES(4), .BIG_ENDIAN(1'b1), .CNT_W(4)) dut_be (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(be_ir), .in_data(in_data),
    .out_valid(be_ov), .out_ready(out_ready), .out_data(be_od),
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
    .flush(flush), .out_nbytes(be_nb),
`endif
    .word_cnt(be_cnt));

  byte_stream_packer #(.NBYTES(4), .BIG_ENDIAN(1'b0), .CNT_W(4)) dut_le (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(le_ir), .in_data(in_data),
    .out_valid(le_ov), .out_ready(out_ready), .out_data(le_od),
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
    .flush(flush), .out_nbytes(le_nb),
`endif
    .word_cnt(le_cnt));

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        r;
    logic        ir;
    logic        ov;
    logic [31:0] be;
    logic [31:0] le;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [7:0] d, logic r);
    @(posedge clk); #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_all(string nm, logic ir, logic ov, logic [31:0] be, logic [31:0] le, logic [3:0] cnt);
    chk({nm, "_be_ir"}, be_ir, ir);   chk({nm, "_le_ir"}, le_ir, ir);
    chk({nm, "_be_ov"}, be_ov, ov);   chk({nm, "_le_ov"}, le_ov, ov);
    chk({nm, "_be_data"}, be_od, be); chk({nm, "_le_data"}, le_od, le);
    chk({nm, "_be_cnt"}, be_cnt, cnt); chk({nm, "_le_cnt"}, le_cnt, cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    byte     q[$];
    bit      m_sv, exp_ir, hs, seen15, stalled;
    logic [31:0] m_be, m_le;
    logic [3:0]  m_cnt;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef BYTE_STREAM_PACKER_FLUSH_EN
    flush = 1'b0;
`endif

    tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'd0};
    tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'd0};
    tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'd0};
    tbl[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'd0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h11223344, 32'h44332211, 4'd0};
    tbl[5]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 32'h11223344, 32'h44332211, 4'd0};
    tbl[6]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 32'h11223344, 32'h44332211, 4'd0};
    tbl[7]  = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 32'h11223344, 32'h44332211, 4'd0};
    tbl[8]  = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 32'h11223344, 32'h44332211, 4'd0};
    tbl[9]  = '{1'b1, 8'h88, 1'b0, 1'b0, 1'b1, 32'h11223344, 32'h44332211, 4'd0};
    tbl[10] = '{1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 32'h11223344, 32'h44332211, 4'd0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 32'h55667788, 32'h88776655, 4'd1};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h55667788, 32'h88776655, 4'd1};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h55667788, 32'h88776655, 4'd2};

    // Reset state, then the table: fill, stall on closing byte, simultaneous drain+load.
    do_reset();
    @(negedge clk);
    chk_all("reset", 1'b1, 1'b0, 32'h0, 32'h0, 4'd0);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      @(negedge clk);
      chk_all($sformatf("tbl%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].be, tbl[i].le, tbl[i].cnt);
    end

    // Reset with a held word and a partial word in flight: both discarded.
    drive(1'b1, 8'hAA, 1'b0); drive(1'b1, 8'hBB, 1'b0);
    drive(1'b1, 8'hCC, 1'b0); drive(1'b1, 8'hDD, 1'b0);
    drive(1'b1, 8'hEE, 1'b0); drive(1'b1, 8'hFF, 1'b0);
    @(posedge clk); #1 rst = 1'b1; in_valid = 1'b1; in_data = 8'h12;
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk_all("midrst", 1'b1, 1'b0, 32'h0, 32'h0, 4'd0);
    drive(1'b1, 8'h01, 1'b1); drive(1'b1, 8'h02, 1'b1);
    drive(1'b1, 8'h03, 1'b1); drive(1'b1, 8'h04, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk_all("postrst", 1'b1, 1'b1, 32'h01020304, 32'h04030201, 4'd0);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk_all("postrst_drain", 1'b1, 1'b0, 32'h01020304, 32'h04030201, 4'd1);

    // 16 back-to-back words: no input stalls, counter hits 15 then wraps to 0.
    do_reset();
    seen15 = 1'b0; stalled = 1'b0;
    for (int w = 0; w < 16; w++)
      for (int b = 0; b < 4; b++) begin
        drive(1'b1, 8'(w * 4 + b), 1'b1);
        @(negedge clk);
        if (!be_ir || !le_ir) stalled = 1'b1;
        if (be_cnt == 4'd15) seen15 = 1'b1;
      end
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    if (be_cnt == 4'd15) seen15 = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("wrap_seen15", seen15, 1'b1);
    chk("wrap_no_stall", stalled, 1'b0);
    chk("wrap_be_cnt", be_cnt, 4'd0);
    chk("wrap_le_cnt", le_cnt, 4'd0);

`ifdef BYTE_STREAM_PACKER_FLUSH_EN
    // Partial-word flush, then a no-op flush with an empty accumulator.
    do_reset();
    drive(1'b1, 8'hAA, 1'b1); drive(1'b1, 8'hBB, 1'b1);
    drive(1'b0, 8'h00, 1'b1); flush = 1'b1;
    drive(1'b0, 8'h00, 1'b0); flush = 1'b0;
    @(negedge clk);
    chk_all("flush", 1'b1, 1'b1, 32'hAABB0000, 32'h0000BBAA, 4'd0);
    chk("flush_be_nb", be_nb, 4'd2);
    chk("flush_le_nb", le_nb, 4'd2);
    drive(1'b0, 8'h00, 1'b1); flush = 1'b1;
    drive(1'b0, 8'h00, 1'b1); flush = 1'b0;
    @(negedge clk);
    chk("flush_noop_be_ov", be_ov, 1'b0);
    chk("flush_noop_le_ov", le_ov, 1'b0);
    chk("flush_noop_cnt", be_cnt, 4'd1);
`endif

    // Random traffic against a byte-queue reference.
    do_reset();
    q.delete(); m_sv = 1'b0; m_be = '0; m_le = '0; m_cnt = '0;
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom % 4) != 0, 8'($urandom), ($urandom % 10) < 7);
      @(negedge clk);
      exp_ir = !(q.size() == 3 && m_sv && !out_ready);
      chk("rnd_be_ir", be_ir, exp_ir);
      chk("rnd_le_ir", le_ir, exp_ir);
      chk("rnd_be_ov", be_ov, m_sv);
      chk("rnd_le_ov", le_ov, m_sv);
      chk("rnd_cnt", be_cnt, m_cnt);
      if (m_sv) begin
        chk("rnd_be_data", be_od, m_be);
        chk("rnd_le_data", le_od, m_le);
      end
      hs = m_sv && out_ready;
      if (in_valid && exp_ir) q.push_back(in_data);
      if (q.size() == 4) begin
        m_be = {q[0], q[1], q[2], q[3]};
        m_le = {q[3], q[2], q[1], q[0]};
        q.delete();
        m_sv = 1'b1;
      end else if (hs) begin
        m_sv = 1'b0;
      end
      if (hs) m_cnt = m_cnt + 4'd1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
